// File: rtl/booth_pkg.sv
// -----------------------------------------------------------------------------
// booth_pkg
// Shared definitions for the radix-4 (modified Booth) multiplier family.
//   booth_state_e : sequencer states of the iterative multiplier
//   booth_sel_e   : magnitude select of one recoded Booth digit (0, M, 2M);
//                   the sign travels separately as a neg flag
//   booth_digits  : number of Booth digits retired for a given operand width
// -----------------------------------------------------------------------------
package booth_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } booth_state_e;

    typedef enum logic [1:0] {
        SEL_ZERO = 2'd0,
        SEL_ONE  = 2'd1,
        SEL_TWO  = 2'd2
    } booth_sel_e;

    // Operands are widened by two bits before recoding, so an even WIDTH
    // needs WIDTH/2 + 1 radix-4 digits to cover the whole extended multiplier.
    function automatic int booth_digits(input int width);
        return width / 2 + 1;
    endfunction

endpackage

// File: rtl/booth_r4_recode.sv
// -----------------------------------------------------------------------------
// booth_r4_recode
// Purely combinational radix-4 Booth recoder, shared by the multiplier
// variants.
//   triplet : {q[i+1], q[i], q[i-1]} overlapping multiplier bits
//   sel     : digit magnitude (booth_sel_e encoding: zero, one, two)
//   neg     : digit is negative (subtract the selected magnitude)
// -----------------------------------------------------------------------------
module booth_r4_recode
    import booth_pkg::*;
(
    input  logic [2:0] triplet,
    output logic [1:0] sel,
    output logic       neg
);

    booth_sel_e sel_e;

    // Standard modified-Booth table. 000 and 111 both mean "no add", so they
    // fall through to the defaults; zero is never paired with neg=1.
    always_comb begin
        sel_e = SEL_ZERO;
        neg   = 1'b0;
        case (triplet)
            3'b001, 3'b010: sel_e = SEL_ONE;
            3'b011:         sel_e = SEL_TWO;
            3'b100: begin
                sel_e = SEL_TWO;
                neg   = 1'b1;
            end
            3'b101, 3'b110: begin
                sel_e = SEL_ONE;
                neg   = 1'b1;
            end
            default: begin
                sel_e = SEL_ZERO;
                neg   = 1'b0;
            end
        endcase
    end

    assign sel = sel_e;

endmodule

// File: rtl/booth_r4_mult.sv
// -----------------------------------------------------------------------------
// booth_r4_mult
// Sequential radix-4 Booth multiplier, one digit per clock, signed or
// unsigned operands of any even WIDTH >= 4. Latency WIDTH/2 + 1 cycles.
//   clk, rst_b    : rising-edge clock, asynchronous active-low reset
//   start         : launch request, honoured only while busy is low
//   signed_mode   : 1 = two's-complement operands, 0 = unsigned
//   x, y          : multiplier / multiplicand, sampled with start
//   busy          : operation in progress
//   done          : one-cycle pulse, product valid
//   product       : 2*WIDTH result, held until the next product is produced
// -----------------------------------------------------------------------------
module booth_r4_mult
    import booth_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst_b,
    input  logic                 start,
    input  logic                 signed_mode,
    input  logic [WIDTH-1:0]     x,
    input  logic [WIDTH-1:0]     y,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int N  = booth_digits(WIDTH);
    localparam int EW = WIDTH + 2;
    localparam int AW = WIDTH + 3;
    localparam int CW = $clog2(N + 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(N - 1);

    booth_state_e state;
    booth_state_e state_next;

    logic [AW-1:0] a_reg;
    logic [EW-1:0] q_reg;
    logic          qneg;
    logic [AW-1:0] m_reg;
    logic [CW-1:0] cnt;

    logic          ext_x;
    logic          ext_y;
    logic [EW-1:0] x_ext;
    logic [EW-1:0] y_ext;

    logic [1:0]    sel;
    logic          neg;
    logic [AW-1:0] magnitude;
    logic [AW-1:0] addend;
    logic [AW-1:0] sum;
    logic [AW-1:0] a_shift;
    logic [EW-1:0] q_shift;

    logic          load_op;
    logic          last_digit;

    // Two extra operand bits make the unsigned case behave like a positive
    // signed number, so the same signed Booth datapath serves both modes.
    assign ext_x = signed_mode & x[WIDTH-1];
    assign ext_y = signed_mode & y[WIDTH-1];
    assign x_ext = {{2{ext_x}}, x};
    assign y_ext = {{2{ext_y}}, y};

    booth_r4_recode u_recode (
        .triplet ({q_reg[1:0], qneg}),
        .sel     (sel),
        .neg     (neg)
    );

    // One adder per cycle: pick 0/M/2M, invert and inject a carry for the
    // negative digits, then shift {A,Q,qneg} right by two with A's sign kept.
    always_comb begin
        magnitude = '0;
        case (sel)
            SEL_ONE: magnitude = m_reg;
            SEL_TWO: magnitude = {m_reg[AW-2:0], 1'b0};
            default: magnitude = '0;
        endcase
        addend  = magnitude ^ {AW{neg}};
        sum     = a_reg + addend + AW'(neg);
        a_shift = {{2{sum[AW-1]}}, sum[AW-1:2]};
        q_shift = {sum[1:0], q_reg[EW-1:2]};
    end

    assign last_digit = (cnt == LAST_CNT);
    assign load_op    = start && (state != RUN);

    // State register; an asynchronous reset abandons any operation in flight.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Sequencer: DONE behaves like IDLE for start, which is what allows a
    // start held through the done pulse to launch the next product directly.
    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (last_digit) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                done = 1'b1;
                if (start) begin
                    state_next = RUN;
                end else begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Datapath registers. The product is captured on the edge that applies
    // the last digit, taking only the low 2*WIDTH bits of the shifted {A,Q}.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            a_reg   <= '0;
            q_reg   <= '0;
            qneg    <= 1'b0;
            m_reg   <= '0;
            cnt     <= '0;
            product <= '0;
        end else if (load_op) begin
            a_reg <= '0;
            q_reg <= x_ext;
            qneg  <= 1'b0;
            m_reg <= {y_ext[EW-1], y_ext};
            cnt   <= '0;
        end else if (state == RUN) begin
            a_reg <= a_shift;
            q_reg <= q_shift;
            qneg  <= q_reg[1];
            cnt   <= cnt + CW'(1);
            if (last_digit) begin
                product <= {a_shift[WIDTH-3:0], q_shift};
            end
        end
    end

endmodule
